// File: rtl/png_scanline_serializer.sv
// rtl/png_scanline_serializer.sv - serializes RGB pixel triplets into raw PNG scanline bytes
module png_scanline_serializer #(
   parameter int          IMG_WIDTH   = 256,
   parameter int          IMG_HEIGHT  = 256,
   parameter logic [7:0]  FILTER_TYPE = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pix_valid,
   output logic       pix_ready,
   input  logic [7:0] pix_r,
   input  logic [7:0] pix_g,
   input  logic [7:0] pix_b,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic [7:0] byte_data,
   output logic       byte_row_start,
   output logic       byte_last,
   output logic       busy,
   output logic       done
);

   localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FILTER   = 3'd1,
      S_WAIT_PIX = 3'd2,
      S_EMIT_R   = 3'd3,
      S_EMIT_G   = 3'd4,
      S_EMIT_B   = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [7:0]       r_q, r_d;
   logic [7:0]       g_q, g_d;
   logic [7:0]       b_q, b_d;

   logic at_col_last;
   logic at_row_last;

   assign at_col_last = (col_q == COL_LAST);
   assign at_row_last = (row_q == ROW_LAST);

   // State, position counters and the captured pixel; reset aborts any frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
      end
   end

   // Next-state: each emitting state advances only on an accepted byte, WAIT_PIX only on an accepted pixel.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      r_d     = r_q;
      g_d     = g_q;
      b_d     = b_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FILTER;
            end
         end
         S_FILTER: begin
            if (byte_ready) begin
               state_d = S_WAIT_PIX;
            end
         end
         S_WAIT_PIX: begin
            if (pix_valid) begin
               r_d     = pix_r;
               g_d     = pix_g;
               b_d     = pix_b;
               state_d = S_EMIT_R;
            end
         end
         S_EMIT_R: begin
            if (byte_ready) begin
               state_d = S_EMIT_G;
            end
         end
         S_EMIT_G: begin
            if (byte_ready) begin
               state_d = S_EMIT_B;
            end
         end
         S_EMIT_B: begin
            if (byte_ready) begin
               if (!at_col_last) begin
                  col_d   = col_q + COL_W'(1);
                  state_d = S_WAIT_PIX;
               end else if (!at_row_last) begin
                  col_d   = '0;
                  row_d   = row_q + ROW_W'(1);
                  state_d = S_FILTER;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            col_d   = '0;
            row_d   = '0;
            r_d     = '0;
            g_d     = '0;
            b_d     = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode from state and registers only, so the stream sideband holds steady under backpressure.
   always_comb begin
      pix_ready      = 1'b0;
      byte_valid     = 1'b0;
      byte_data      = 8'h00;
      byte_row_start = 1'b0;
      byte_last      = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;

      case (state_q)
         S_FILTER: begin
            busy           = 1'b1;
            byte_valid     = 1'b1;
            byte_data      = FILTER_TYPE;
            byte_row_start = 1'b1;
         end
         S_WAIT_PIX: begin
            busy      = 1'b1;
            pix_ready = 1'b1;
         end
         S_EMIT_R: begin
            busy       = 1'b1;
            byte_valid = 1'b1;
            byte_data  = r_q;
         end
         S_EMIT_G: begin
            busy       = 1'b1;
            byte_valid = 1'b1;
            byte_data  = g_q;
         end
         S_EMIT_B: begin
            busy       = 1'b1;
            byte_valid = 1'b1;
            byte_data  = b_q;
            byte_last  = at_col_last && at_row_last;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_png_scanline_serializer.sv
// tb/tb_png_scanline_serializer.sv - randomized self-checking bench for png_scanline_serializer
module tb_png_scanline_serializer;

   localparam int         W        = 4;
   localparam int         H        = 2;
   localparam logic [7:0] FILTER_T = 8'h00;
   localparam int         FRAME_BYTES = H * (1 + 3 * W);

   logic       clk;
   logic       rst;
   logic       start;
   logic       pix_valid;
   logic       pix_ready;
   logic [7:0] pix_r, pix_g, pix_b;
   logic       byte_valid;
   logic       byte_ready;
   logic [7:0] byte_data;
   logic       byte_row_start;
   logic       byte_last;
   logic       busy;
   logic       done;

   png_scanline_serializer #(
      .IMG_WIDTH   (W),
      .IMG_HEIGHT  (H),
      .FILTER_TYPE (FILTER_T)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .pix_valid      (pix_valid),
      .pix_ready      (pix_ready),
      .pix_r          (pix_r),
      .pix_g          (pix_g),
      .pix_b          (pix_b),
      .byte_valid     (byte_valid),
      .byte_ready     (byte_ready),
      .byte_data      (byte_data),
      .byte_row_start (byte_row_start),
      .byte_last      (byte_last),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   int n_pass;
   int n_total;

   // captured stream and protocol observations
   logic [7:0]  got_data[$];
   bit          got_rs[$];
   bit          got_last[$];
   logic [7:0]  exp_data[$];
   bit          exp_rs[$];
   bit          exp_last[$];
   logic [23:0] frame_pix[$];
   logic [23:0] src[$];
   int          done_cnt, busy_err, hold_err, excl_err, lat_err;
   bit          prev_stall;
   logic [9:0]  prev_out;
   bit          prev_pix_xfer;
   logic [7:0]  prev_r;

   task automatic clear_capture();
      got_data.delete(); got_rs.delete(); got_last.delete();
      done_cnt = 0; busy_err = 0; hold_err = 0; excl_err = 0; lat_err = 0;
      prev_stall = 0; prev_out = '0; prev_pix_xfer = 0; prev_r = '0;
   endtask

   // Reference: every row is the filter byte then R,G,B per column; last flag on the frame's final byte.
   function automatic void build_expected();
      exp_data.delete(); exp_rs.delete(); exp_last.delete();
      for (int row = 0; row < H; row++) begin
         exp_data.push_back(FILTER_T); exp_rs.push_back(1'b1); exp_last.push_back(1'b0);
         for (int c = 0; c < W; c++) begin
            logic [23:0] p;
            p = frame_pix[row * W + c];
            exp_data.push_back(p[23:16]); exp_rs.push_back(1'b0); exp_last.push_back(1'b0);
            exp_data.push_back(p[15:8]);  exp_rs.push_back(1'b0); exp_last.push_back(1'b0);
            exp_data.push_back(p[7:0]);   exp_rs.push_back(1'b0);
            exp_last.push_back((row == H - 1) && (c == W - 1));
         end
      end
   endfunction

   function automatic void load_frame(input bit counting);
      frame_pix.delete();
      for (int i = 0; i < W * H; i++) begin
         if (counting) frame_pix.push_back({3{8'(i + 1)}});
         else          frame_pix.push_back(24'($urandom));
      end
      src = frame_pix;
      build_expected();
   endfunction

   function automatic int first_diff();
      int n;
      n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
      for (int i = 0; i < n; i++) begin
         if (got_data[i] !== exp_data[i] || got_rs[i] !== exp_rs[i] || got_last[i] !== exp_last[i])
            return i;
      end
      if (got_data.size() != exp_data.size()) return n;
      return -1;
   endfunction

   function automatic string show_at(input int i);
      string g, e;
      g = (i < got_data.size()) ? $sformatf("%02h/rs%0d/last%0d", got_data[i], got_rs[i], got_last[i]) : "none";
      e = (i < exp_data.size()) ? $sformatf("%02h/rs%0d/last%0d", exp_data[i], exp_rs[i], exp_last[i]) : "none";
      return $sformatf("byte %0d got %s expected %s", i, g, e);
   endfunction

   task automatic drive_inputs(input int rdy_pct, input int pv_pct);
      byte_ready = ($urandom_range(0, 99) < rdy_pct);
      if (src.size() > 0) begin
         pix_valid = ($urandom_range(0, 99) < pv_pct);
         {pix_r, pix_g, pix_b} = src[0];
      end else begin
         pix_valid = 1'b0;
      end
   endtask

   // Observe one cycle at the falling edge, then return just after the next rising edge.
   task automatic sample_cycle();
      @(negedge clk);
      if (prev_pix_xfer && !(byte_valid && byte_data == prev_r)) lat_err++;
      if (prev_stall && (!byte_valid || {byte_data, byte_row_start, byte_last} != prev_out)) hold_err++;
      if (pix_ready && byte_valid) excl_err++;
      if (done) begin
         done_cnt++;
         if (busy) busy_err++;
      end
      if (byte_valid && byte_ready) begin
         got_data.push_back(byte_data); got_rs.push_back(byte_row_start); got_last.push_back(byte_last);
      end
      prev_stall    = byte_valid && !byte_ready;
      prev_out      = {byte_data, byte_row_start, byte_last};
      prev_pix_xfer = pix_valid && pix_ready;
      prev_r        = pix_r;
      if (prev_pix_xfer && src.size() > 0) void'(src.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic kick();
      start = 1'b1;
      drive_inputs(100, 100);
      sample_cycle();
      start = 1'b0;
   endtask

   task automatic run_to_done(input int rdy_pct, input int pv_pct);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         drive_inputs(rdy_pct, pv_pct);
         sample_cycle();
         n++;
      end
      repeat (4) begin
         drive_inputs(rdy_pct, pv_pct);
         sample_cycle();
      end
   endtask

   task automatic test_reset();
      int pr, bv;
      rst = 1'b1; pix_valid = 1'b1; byte_ready = 1'b1; start = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({pix_ready, byte_valid, byte_row_start, byte_last, busy, done} !== 6'b0)
         $display("FAIL reset_ctrl: got %b expected 000000", {pix_ready, byte_valid, byte_row_start, byte_last, busy, done});
      else n_pass++;
      n_total++;
      if (byte_data !== 8'h00) $display("FAIL reset_data: got %02h expected 00", byte_data);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      pr = 0; bv = 0;
      repeat (10) begin
         @(negedge clk);
         if (pix_ready) pr++;
         if (byte_valid) bv++;
         @(posedge clk); #1;
      end
      n_total++;
      if (pr !== 0) $display("FAIL idle_pix_ready: got %0d high cycles expected 0", pr);
      else n_pass++;
      n_total++;
      if (bv !== 0 || busy !== 1'b0) $display("FAIL idle_no_bytes: got %0d bytes busy=%0b expected 0 bytes busy=0", bv, busy);
      else n_pass++;
      pix_valid = 1'b0;
   endtask

   task automatic test_full_frame();
      int d;
      clear_capture();
      load_frame(1'b1);
      kick();
      n_total++;
      if ({busy, byte_valid, byte_row_start} !== 3'b111 || byte_data !== FILTER_T)
         $display("FAIL frame_first_byte: got busy/valid/rs=%b data=%02h expected 111 data=%02h", {busy, byte_valid, byte_row_start}, byte_data, FILTER_T);
      else n_pass++;
      run_to_done(100, 100);
      n_total++;
      if (got_data.size() !== FRAME_BYTES) $display("FAIL full_frame_count: got %0d expected %0d", got_data.size(), FRAME_BYTES);
      else n_pass++;
      d = first_diff();
      n_total++;
      if (d !== -1) $display("FAIL full_frame_bytes: %s", show_at(d));
      else n_pass++;
      n_total++;
      if (done_cnt !== 1 || busy_err !== 0) $display("FAIL full_frame_done: got %0d pulses %0d busy-at-done expected 1 and 0", done_cnt, busy_err);
      else n_pass++;
      n_total++;
      if (lat_err !== 0 || hold_err !== 0 || excl_err !== 0)
         $display("FAIL full_frame_protocol: got lat=%0d hold=%0d excl=%0d expected 0", lat_err, hold_err, excl_err);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int stall_left, n, d;
      clear_capture();
      load_frame(1'b0);
      frame_pix[0] = 24'hAABBCC;
      src = frame_pix;
      build_expected();
      kick();
      stall_left = 3;
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         drive_inputs(100, 100);
         if (stall_left > 0 && byte_valid && byte_data == 8'hBB && got_data.size() == 2) begin
            byte_ready = 1'b0;
            stall_left--;
            sample_cycle();
            n_total++;
            if (byte_valid !== 1'b1 || byte_data !== 8'hBB || pix_ready !== 1'b0)
               $display("FAIL bp_hold: got valid=%0b data=%02h pix_ready=%0b expected 1 BB 0", byte_valid, byte_data, pix_ready);
            else n_pass++;
         end else begin
            sample_cycle();
         end
         n++;
      end
      n_total++;
      if (stall_left !== 0) $display("FAIL bp_stalls_applied: got %0d remaining expected 0", stall_left);
      else n_pass++;
      d = first_diff();
      n_total++;
      if (d !== -1) $display("FAIL bp_bytes: %s", show_at(d));
      else n_pass++;
      n_total++;
      if (hold_err !== 0 || done_cnt !== 1) $display("FAIL bp_protocol: got hold=%0d done=%0d expected 0 and 1", hold_err, done_cnt);
      else n_pass++;
   endtask

   task automatic test_starvation();
      int starve_left, n, d;
      clear_capture();
      load_frame(1'b0);
      kick();
      starve_left = 5;
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         drive_inputs(100, 100);
         if (starve_left > 0 && pix_ready && got_data.size() >= 4) begin
            pix_valid = 1'b0;
            starve_left--;
            sample_cycle();
            n_total++;
            if (byte_valid !== 1'b0 || pix_ready !== 1'b1)
               $display("FAIL starve_wait: got valid=%0b pix_ready=%0b expected 0 1", byte_valid, pix_ready);
            else n_pass++;
         end else begin
            sample_cycle();
         end
         n++;
      end
      d = first_diff();
      n_total++;
      if (d !== -1 || starve_left !== 0) $display("FAIL starve_bytes: starve_left=%0d %s", starve_left, show_at(d));
      else n_pass++;
   endtask

   task automatic test_start_while_busy();
      int n, d;
      clear_capture();
      load_frame(1'b0);
      kick();
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         drive_inputs(70, 70);
         start = (n == 20 || n == 21);
         sample_cycle();
         n++;
      end
      start = 1'b0;
      repeat (6) begin
         drive_inputs(70, 70);
         sample_cycle();
      end
      d = first_diff();
      n_total++;
      if (d !== -1) $display("FAIL busy_start_bytes: %s", show_at(d));
      else n_pass++;
      n_total++;
      if (done_cnt !== 1 || busy !== 1'b0) $display("FAIL busy_start_done: got %0d pulses busy=%0b expected 1 busy=0", done_cnt, busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int n, d;
      clear_capture();
      load_frame(1'b0);
      kick();
      n = 0;
      while (got_data.size() < 7 && n < 500) begin
         drive_inputs(100, 100);
         sample_cycle();
         n++;
      end
      rst = 1'b1;
      #1;
      n_total++;
      if ({pix_ready, byte_valid, byte_row_start, byte_last, busy, done} !== 6'b0 || byte_data !== 8'h00 || got_data.size() !== 7)
         $display("FAIL abort_outputs: got ctrl=%b data=%02h bytes=%0d expected 000000 00 7",
                  {pix_ready, byte_valid, byte_row_start, byte_last, busy, done}, byte_data, got_data.size());
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_capture();
      load_frame(1'b0);
      kick();
      run_to_done(80, 80);
      d = first_diff();
      n_total++;
      if (d !== -1) $display("FAIL restart_bytes: %s", show_at(d));
      else n_pass++;
      n_total++;
      if (got_data.size() == 0 || got_data[0] !== FILTER_T || got_rs[0] !== 1'b1)
         $display("FAIL restart_first: got %0d bytes expected filter byte %02h first", got_data.size(), FILTER_T);
      else n_pass++;
   endtask

   task automatic test_random_frames();
      int d;
      for (int f = 0; f < 4; f++) begin
         clear_capture();
         load_frame(1'b0);
         kick();
         run_to_done($urandom_range(30, 100), $urandom_range(30, 100));
         d = first_diff();
         n_total++;
         if (d !== -1) $display("FAIL random_frame_%0d_bytes: %s", f, show_at(d));
         else n_pass++;
         n_total++;
         if (done_cnt !== 1 || busy_err + hold_err + excl_err + lat_err !== 0)
            $display("FAIL random_frame_%0d_protocol: got done=%0d errs=%0d expected 1 and 0", f, done_cnt, busy_err + hold_err + excl_err + lat_err);
         else n_pass++;
      end
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1; start = 1'b0; pix_valid = 1'b0; byte_ready = 1'b0;
      pix_r = '0; pix_g = '0; pix_b = '0;
      n_pass = 0; n_total = 0;
      clear_capture();
      test_reset();
      test_full_frame();
      test_backpressure();
      test_starvation();
      test_start_while_busy();
      test_reset_mid_frame();
      test_random_frames();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
